// File: rtl/vga_pkg.sv
// Framebuffer geometry and prefetch FSM encoding shared by the VGA output path
// and the SRAM request handler.
package vga_pkg;

    localparam logic [31:0] FB_BASE_ADDR      = 32'h3E80;
    localparam int unsigned FB_WORDS_PER_LINE = 4;
    localparam int unsigned FB_LINES          = 96;
    localparam int unsigned FB_WIDTH          = 128;
    localparam int unsigned FB_HEIGHT         = 96;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned BSEL_W     = 4;
    localparam int unsigned LINE_IDX_W = 7;
    localparam int unsigned PIX_X_W    = 7;
    localparam int unsigned WCNT_W     = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } prefetch_state_t;

endpackage

// File: rtl/vga_line_prefetch_if.sv
// Shared SRAM read port as seen by the line prefetcher (master) and the arbiter/SRAM side (slave).
interface vga_line_prefetch_if;
    import vga_pkg::*;

    logic                rd_req;
    logic [ADDR_W-1:0]   rd_addr;
    logic [BSEL_W-1:0]   byte_select;
    logic                bus_grant;
    logic                SRAM_busy;
    logic [WORD_W-1:0]   SRAM_data_in;

    modport master (
        output rd_req, rd_addr, byte_select,
        input  bus_grant, SRAM_busy, SRAM_data_in
    );

    modport slave (
        input  rd_req, rd_addr, byte_select,
        output bus_grant, SRAM_busy, SRAM_data_in
    );

endinterface

// File: rtl/vga_line_buf.sv
// Ping-pong line storage: two buffers of four 32-bit words, word write port and
// single-pixel combinational read port.
module vga_line_buf
    import vga_pkg::*;
(
    input  logic                  clk,
    input  logic                  wr_sel,
    input  logic [WCNT_W-1:0]     wr_word,
    input  logic [WORD_W-1:0]     wr_data,
    input  logic                  wr_en,
    input  logic                  rd_sel,
    input  logic [PIX_X_W-1:0]    rd_pix,
    output logic                  rd_bit_c
);

    logic [WORD_W-1:0] mem_q [2][FB_WORDS_PER_LINE];

    // Contents carry no reset; validity is tracked by the owner.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_sel][wr_word] <= wr_data;
        end
    end

    assign rd_bit_c = mem_q[rd_sel][rd_pix[6:5]][rd_pix[4:0]];

endmodule

// File: rtl/vga_line_prefetch.sv
// Fetches the next framebuffer line from SRAM into the back half of a ping-pong
// buffer while the front half feeds pixel output.
module vga_line_prefetch
    import vga_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = FB_BASE_ADDR,
    parameter int unsigned WORDS_PER_LINE = FB_WORDS_PER_LINE,
    parameter int unsigned LINES          = FB_LINES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   line_start,
    input  logic [LINE_IDX_W-1:0]  line_idx,
    input  logic                   swap,
    input  logic                   pix_en,
    input  logic [PIX_X_W-1:0]     pix_x,
    output logic                   pixel_data,
    vga_line_prefetch_if.master    sram,
    output logic                   fetch_busy,
    output logic                   underrun,
    output logic                   line_drop
);

    prefetch_state_t         state_q, state_d;
    logic [LINE_IDX_W-1:0]   line_q, line_d;
    logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
    logic                    sel_q, sel_d;
    logic                    front_valid_q, front_valid_d;
    logic                    back_valid_q, back_valid_d;
    logic                    underrun_d, line_drop_d;
    logic                    pixel_d;
    logic [ADDR_W-1:0]       rd_addr_d;
    logic                    accept_c, last_c, pix_bit_c;

    assign accept_c = (state_q == FETCH) & sram.bus_grant & ~sram.SRAM_busy;
    assign last_c   = accept_c & (wcnt_q == WCNT_W'(WORDS_PER_LINE - 1));

    // Next-state, buffer bookkeeping and registered-output values.
    always_comb begin
        state_d       = state_q;
        line_d        = line_q;
        wcnt_d        = wcnt_q;
        sel_d         = sel_q;
        front_valid_d = front_valid_q;
        back_valid_d  = back_valid_q;
        underrun_d    = underrun;
        line_drop_d   = line_drop;

        case (state_q)
            IDLE: begin
                if (line_start && (32'(line_idx) < LINES)) begin
                    state_d = FETCH;
                    line_d  = line_idx;
                    wcnt_d  = '0;
                end
            end
            FETCH: begin
                if (line_start) begin
                    line_drop_d = 1'b1;
                end
                if (accept_c) begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                    if (last_c) begin
                        state_d      = IDLE;
                        back_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A final accept in the swap cycle still lands in the buffer that becomes front.
        if (swap) begin
            sel_d         = ~sel_q;
            front_valid_d = back_valid_q | last_c;
            back_valid_d  = 1'b0;
            if (!(back_valid_q | last_c)) begin
                underrun_d = 1'b1;
                if (state_q == FETCH) begin
                    state_d = IDLE;
                end
            end
        end

        pixel_d   = pix_en & front_valid_q & pix_bit_c;
        rd_addr_d = BASE_ADDR + (32'(line_d) * 32'(WORDS_PER_LINE)) + 32'(wcnt_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            line_q           <= '0;
            wcnt_q           <= '0;
            sel_q            <= 1'b0;
            front_valid_q    <= 1'b0;
            back_valid_q     <= 1'b0;
            underrun         <= 1'b0;
            line_drop        <= 1'b0;
            pixel_data       <= 1'b0;
            fetch_busy       <= 1'b0;
            sram.rd_req      <= 1'b0;
            sram.byte_select <= '0;
            sram.rd_addr     <= BASE_ADDR;
        end else begin
            state_q          <= state_d;
            line_q           <= line_d;
            wcnt_q           <= wcnt_d;
            sel_q            <= sel_d;
            front_valid_q    <= front_valid_d;
            back_valid_q     <= back_valid_d;
            underrun         <= underrun_d;
            line_drop        <= line_drop_d;
            pixel_data       <= pixel_d;
            fetch_busy       <= (state_d == FETCH);
            sram.rd_req      <= (state_d == FETCH);
            sram.byte_select <= {BSEL_W{state_d == FETCH}};
            sram.rd_addr     <= rd_addr_d;
        end
    end

    vga_line_buf u_line_buf (
        .clk      (clk),
        .wr_sel   (~sel_q),
        .wr_word  (wcnt_q),
        .wr_data  (sram.SRAM_data_in),
        .wr_en    (accept_c),
        .rd_sel   (sel_q),
        .rd_pix   (pix_x),
        .rd_bit_c (pix_bit_c)
    );

endmodule

// File: tb/tb_vga_line_prefetch.sv
// Randomized and directed bench for vga_line_prefetch against a line-level
// reference model that swaps whole front/back line arrays.
module tb_vga_line_prefetch;
    import vga_pkg::*;

    logic       clk = 1'b0;
    logic       rst, line_start, swap, pix_en;
    logic [6:0] line_idx, pix_x;
    logic       pixel_data, fetch_busy, underrun, line_drop;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vga_line_prefetch_if bus ();

    vga_line_prefetch dut (
        .clk        (clk),
        .rst        (rst),
        .line_start (line_start),
        .line_idx   (line_idx),
        .swap       (swap),
        .pix_en     (pix_en),
        .pix_x      (pix_x),
        .pixel_data (pixel_data),
        .sram       (bus),
        .fetch_busy (fetch_busy),
        .underrun   (underrun),
        .line_drop  (line_drop)
    );

    // Reference model state: whole lines, no select bit.
    logic [31:0] m_front [4];
    logic [31:0] m_back  [4];
    bit m_fetch, m_fok, m_bok, m_under, m_drop, m_pix;
    int m_line, m_words;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        bit was, acc, done;
        logic [31:0] tmp [4];
        if (rst) begin
            m_fetch = 0; m_fok = 0; m_bok = 0; m_under = 0; m_drop = 0;
            m_pix = 0; m_line = 0; m_words = 0;
        end else begin
            was   = m_fetch;
            m_pix = (pix_en && m_fok) ? m_front[int'(pix_x) / 32][int'(pix_x) % 32] : 1'b0;
            acc   = was && bus.bus_grant && !bus.SRAM_busy;
            done  = acc && (m_words == 3);
            if (acc) begin
                m_back[m_words] = bus.SRAM_data_in;
                m_words++;
            end
            if (was && line_start) m_drop = 1;
            if (!was && line_start && int'(line_idx) < 96) begin
                m_fetch = 1; m_line = int'(line_idx); m_words = 0;
            end
            if (done) begin
                m_fetch = 0; m_bok = 1;
            end
            if (swap) begin
                if (!m_bok) begin
                    m_under = 1;
                    if (was) m_fetch = 0;
                end
                tmp = m_front; m_front = m_back; m_back = tmp;
                m_fok = m_bok;
                m_bok = 0;
            end
        end
    endtask

    task automatic compare();
        chk("pixel", 32'(pixel_data), 32'(m_pix));
        chk("rd_req", 32'(bus.rd_req), 32'(m_fetch));
        chk("fetch_busy", 32'(fetch_busy), 32'(m_fetch));
        chk("byte_select", 32'(bus.byte_select), m_fetch ? 32'hF : 32'h0);
        chk("underrun", 32'(underrun), 32'(m_under));
        chk("line_drop", 32'(line_drop), 32'(m_drop));
        if (m_fetch) chk("rd_addr", bus.rd_addr, 32'h3E80 + 32'(m_line * 4 + m_words));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    task automatic quiet();
        rst = 0; line_start = 0; line_idx = 0; swap = 0; pix_en = 0; pix_x = 0;
        bus.bus_grant = 1; bus.SRAM_busy = 0; bus.SRAM_data_in = 0;
    endtask

    task automatic start_line(input int idx);
        line_start = 1; line_idx = 7'(idx);
        step();
        line_start = 0;
    endtask

    task automatic feed_words(input int n);
        for (int i = 0; i < n; i++) begin
            bus.SRAM_data_in = $urandom;
            step();
        end
    endtask

    task automatic sweep(output int ones);
        ones = 0;
        for (int x = 0; x < 128; x++) begin
            pix_en = 1; pix_x = 7'(x);
            step();
            ones += int'(pixel_data);
        end
        pix_en = 0;
    endtask

    task automatic do_swap();
        swap = 1;
        step();
        swap = 0;
    endtask

    initial begin
        logic [31:0] pat [4];
        int ones;
        quiet();
        rst = 1;
        step(); step();
        rst = 0;
        chk("reset_addr", bus.rd_addr, 32'h3E80);
        chk("reset_req", 32'(bus.rd_req), 0);

        // Line 5, back-to-back accepts; pixels only at the two extremes.
        pat[0] = 32'h0000_0001; pat[1] = 0; pat[2] = 0; pat[3] = 32'h8000_0000;
        start_line(5);
        for (int i = 0; i < 4; i++) begin
            chk("seq_addr", bus.rd_addr, 32'h3E94 + 32'(i));
            bus.SRAM_data_in = pat[i];
            step();
        end
        chk("seq_done_busy", 32'(fetch_busy), 0);
        do_swap();
        sweep(ones);
        chk("edge_ones", 32'(ones), 2);

        // SRAM stall mid-fetch with changing data on the bus.
        start_line(10);
        feed_words(1);
        bus.SRAM_busy = 1;
        for (int i = 0; i < 3; i++) begin
            bus.SRAM_data_in = $urandom;
            step();
            chk("stall_addr", bus.rd_addr, 32'h3EA9);
        end
        bus.SRAM_busy = 0;
        feed_words(3);
        do_swap();
        sweep(ones);

        // Underrun: swap after two accepts.
        start_line(11);
        feed_words(2);
        do_swap();
        chk("underrun_set", 32'(underrun), 1);
        chk("underrun_idle", 32'(fetch_busy), 0);
        sweep(ones);
        chk("underrun_dark", 32'(ones), 0);
        start_line(12);
        feed_words(4);
        do_swap();
        sweep(ones);
        chk("underrun_sticky", 32'(underrun), 1);

        // line_start during FETCH is dropped; fetch keeps its address.
        start_line(20);
        line_start = 1; line_idx = 7'd30;
        feed_words(1);
        line_start = 0;
        chk("drop_flag", 32'(line_drop), 1);
        chk("drop_addr", bus.rd_addr, 32'h3ED1);
        feed_words(3);

        // Out-of-range line index is ignored.
        start_line(96);
        chk("idx96_req", 32'(bus.rd_req), 0);
        step();
        chk("idx96_req2", 32'(bus.rd_req), 0);

        // Swap coinciding with final accept after a fresh reset.
        rst = 1; step(); rst = 0;
        start_line(40);
        feed_words(3);
        bus.SRAM_data_in = 32'h0000_000F;
        swap = 1;
        step();
        swap = 0;
        chk("final_swap_under", 32'(underrun), 0);
        chk("final_swap_busy", 32'(fetch_busy), 0);
        sweep(ones);
        chk("final_swap_word3", 32'(m_front[3]), 32'h0000_000F);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rst               = ($urandom_range(0, 599) == 0);
            line_start        = ($urandom_range(0, 11) == 0);
            line_idx          = 7'($urandom_range(0, 105));
            swap              = ($urandom_range(0, 29) == 0);
            pix_en            = 1'($urandom);
            pix_x             = 7'($urandom);
            bus.bus_grant     = ($urandom_range(0, 3) != 0);
            bus.SRAM_busy     = ($urandom_range(0, 3) == 0);
            bus.SRAM_data_in  = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
